// File: rtl/orb_wr_arbiter.sv
// Write-side arbiter for the ping-pong orbit frame RAMs: one buffered slot per source,
// round-robin drain onto a single registered write port. Optional macro: ORB_WR_ARB_STATS_EN.
module orb_wr_arbiter #(
    parameter int N  = 5,
    parameter int AW = 11,
    parameter int DW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sw,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    input  logic [N*DW-1:0] data,
    input  logic            clr_ovf,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic            wren_a,
    output logic            wren_b,
    output logic            busy,
    output logic [N-1:0]    ovf,
    output logic [15:0]     drop_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  r_pend;
    logic [PW-1:0] r_rr_ptr;
    logic [AW-1:0] r_slot_addr [N];
    logic [DW-1:0] r_slot_data [N];
    logic          r_slot_tag  [N];
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_wren_a;
    logic          r_wren_b;
    logic [N-1:0]  r_ovf;

    logic          w_gnt_vld;
    logic [PW-1:0] w_gnt_idx;
    logic [N-1:0]  w_gnt_oh;
    logic [N-1:0]  w_drop;

    // Index arithmetic modulo N; off is always below N so one wrap suffices.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_gnt_vld && r_pend[wrap_inc(r_rr_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = wrap_inc(r_rr_ptr, k);
                w_gnt_oh[wrap_inc(r_rr_ptr, k)] = 1'b1;
            end
        end
    end

    // A strobe into an occupied slot survives only if that slot drains on the same edge.
    assign w_drop = req & r_pend & ~w_gnt_oh;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_rr_ptr  <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wren_a  <= 1'b0;
            r_wren_b  <= 1'b0;
            r_ovf     <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gnt_oh) | (req & ~w_drop);
            r_ovf  <= (clr_ovf ? '0 : r_ovf) | w_drop;
            if (w_gnt_vld) begin
                r_wr_addr <= r_slot_addr[w_gnt_idx];
                r_wr_data <= r_slot_data[w_gnt_idx];
                r_wren_a  <= r_slot_tag[w_gnt_idx];
                r_wren_b  <= ~r_slot_tag[w_gnt_idx];
                r_rr_ptr  <= wrap_inc(w_gnt_idx, 1);
            end else begin
                r_wren_a  <= 1'b0;
                r_wren_b  <= 1'b0;
            end
        end
    end

    // NOTE: slot storage has no reset; its contents are only ever read while r_pend marks them valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req[i] && !w_drop[i]) begin
                r_slot_addr[i] <= addr[i*AW +: AW];
                r_slot_data[i] <= data[i*DW +: DW];
                r_slot_tag[i]  <= sw;
            end
        end
    end

    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign wren_a  = r_wren_a;
    assign wren_b  = r_wren_b;
    assign busy    = |r_pend;
    assign ovf     = r_ovf;

`ifdef ORB_WR_ARB_STATS_EN
    localparam int CW = PW + 1;

    logic [15:0]   r_drop_cnt;
    logic [CW-1:0] w_drop_num;
    logic [16:0]   w_cnt_sum;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < N; i++) begin
            w_drop_num = w_drop_num + CW'(w_drop[i]);
        end
        w_cnt_sum = {1'b0, (clr_ovf ? 16'h0000 : r_drop_cnt)} + 17'(w_drop_num);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Self-checking bench for orb_wr_arbiter: directed vector table, hand-written corner
// sequences, and random traffic against a per-source slot model.
module tb_orb_wr_arbiter;

    localparam int N  = 5;
    localparam int AW = 11;
    localparam int DW = 12;
`ifdef ORB_WR_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sw = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] data = '0;
    logic            clr_ovf = 1'b0;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wren_a;
    logic            wren_b;
    logic            busy;
    logic [N-1:0]    ovf;
    logic [15:0]     drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    orb_wr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .req      (req),
        .addr     (addr),
        .data     (data),
        .clr_ovf  (clr_ovf),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wren_a   (wren_a),
        .wren_b   (wren_b),
        .busy     (busy),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: one slot per source, fair rotating scan ----------------
    bit          m_pend [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    bit          m_tag  [N];
    int          m_ptr;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit          m_wa, m_wb;
    logic [N-1:0] m_ovf;
    int          m_cnt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr = 0; m_wr_addr = '0; m_wr_data = '0;
        m_wa = 1'b0; m_wb = 1'b0; m_ovf = '0; m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int g;
        int drops;
        int s;
        logic [N-1:0] nxt_ovf;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && m_pend[idx]) g = idx;
        end
        nxt_ovf = clr_ovf ? '0 : m_ovf;
        if (g >= 0) begin
            m_wr_addr = m_addr[g];
            m_wr_data = m_data[g];
            m_wa = m_tag[g];
            m_wb = !m_tag[g];
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % N;
        end else begin
            m_wa = 1'b0;
            m_wb = 1'b0;
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (m_pend[i]) begin
                    drops++;
                    nxt_ovf[i] = 1'b1;
                end else begin
                    m_pend[i] = 1'b1;
                    m_addr[i] = addr[i*AW +: AW];
                    m_data[i] = data[i*DW +: DW];
                    m_tag[i]  = sw;
                end
            end
        end
        m_ovf = nxt_ovf;
        s = (clr_ovf ? 0 : m_cnt) + drops;
        m_cnt = (s > 65535) ? 65535 : s;
    endtask

    function automatic bit model_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < N; i++) b = b | m_pend[i];
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_srcs(input logic [AW-1:0] abase, input logic [DW-1:0] dbase);
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = abase + AW'(i);
            data[i*DW +: DW] = dbase + DW'(i);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          do_rst;
        logic        sw;
        logic [N-1:0] req;
        logic        clr;
        logic [AW-1:0] abase;
        logic [DW-1:0] dbase;
        logic        exp_a;
        logic        exp_b;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic        exp_busy;
        logic [N-1:0] exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic s, logic [N-1:0] q, logic c, logic [AW-1:0] ab,
                                logic [DW-1:0] db, logic ea, logic eb, logic [AW-1:0] exa,
                                logic [DW-1:0] exd, logic ebz, logic [N-1:0] eo, logic [15:0] ec);
        vec_t v;
        v.do_rst = r; v.sw = s; v.req = q; v.clr = c; v.abase = ab; v.dbase = db;
        v.exp_a = ea; v.exp_b = eb; v.exp_addr = exa; v.exp_data = exd;
        v.exp_busy = ebz; v.exp_ovf = eo; v.exp_cnt = ec;
        return v;
    endfunction

    initial begin
        int na;
        int nb;

        // single request from source 0 into RAM B
        tbl.push_back(mk(1, 0, 5'b00001, 0, 11'h010, 12'hABC, 0, 0, 11'h000, 12'h000, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h010, 12'hABC, 0, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 0, 11'h010, 12'hABC, 0, 5'b0, 16'd0));
        // all five sources strobing together after reset drain 0..4 into RAM A
        tbl.push_back(mk(1, 1, 5'b11111, 0, 11'h000, 12'h100, 0, 0, 11'h000, 12'h000, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 11'h000, 12'h000, 1, 0, 11'h000, 12'h100, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 11'h000, 12'h000, 1, 0, 11'h001, 12'h101, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 11'h000, 12'h000, 1, 0, 11'h002, 12'h102, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 11'h000, 12'h000, 1, 0, 11'h003, 12'h103, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 11'h000, 12'h000, 1, 0, 11'h004, 12'h104, 0, 5'b0, 16'd0));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 11'h000, 12'h000, 0, 0, 11'h004, 12'h104, 0, 5'b0, 16'd0));
        // grant to source 2, then 0 and 3 together: 3 must go first
        tbl.push_back(mk(0, 0, 5'b00100, 0, 11'h020, 12'h200, 0, 0, 11'h004, 12'h104, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h022, 12'h202, 0, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b01001, 0, 11'h030, 12'h300, 0, 0, 11'h022, 12'h202, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h033, 12'h303, 1, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h030, 12'h300, 0, 5'b0, 16'd0));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 0, 11'h030, 12'h300, 0, 5'b0, 16'd0));
        // overflow: source 4 strobes again while its old entry waits
        tbl.push_back(mk(1, 0, 5'b11111, 0, 11'h040, 12'h400, 0, 0, 11'h000, 12'h000, 1, 5'b00000, 16'd0));
        tbl.push_back(mk(0, 0, 5'b10000, 0, 11'h050, 12'h500, 0, 1, 11'h040, 12'h400, 1, 5'b10000, 16'd1));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h041, 12'h401, 1, 5'b10000, 16'd1));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h042, 12'h402, 1, 5'b10000, 16'd1));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h043, 12'h403, 1, 5'b10000, 16'd1));
        tbl.push_back(mk(0, 0, 5'b00000, 0, 11'h000, 12'h000, 0, 1, 11'h044, 12'h404, 0, 5'b10000, 16'd1));
        tbl.push_back(mk(0, 0, 5'b00000, 1, 11'h000, 12'h000, 0, 0, 11'h044, 12'h404, 0, 5'b00000, 16'd0));

        do_reset();
        check("reset wren_a", 32'(wren_a), 32'd0);
        check("reset wren_b", 32'(wren_b), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);

        for (int v = 0; v < tbl.size(); v++) begin
            if (tbl[v].do_rst) do_reset();
            sw = tbl[v].sw;
            req = tbl[v].req;
            clr_ovf = tbl[v].clr;
            set_srcs(tbl[v].abase, tbl[v].dbase);
            @(posedge clk);
            #1;
            req = '0;
            clr_ovf = 1'b0;
            check($sformatf("v%0d wren_a", v), 32'(wren_a), 32'(tbl[v].exp_a));
            check($sformatf("v%0d wren_b", v), 32'(wren_b), 32'(tbl[v].exp_b));
            check($sformatf("v%0d wr_addr", v), 32'(wr_addr), 32'(tbl[v].exp_addr));
            check($sformatf("v%0d wr_data", v), 32'(wr_data), 32'(tbl[v].exp_data));
            check($sformatf("v%0d busy", v), 32'(busy), 32'(tbl[v].exp_busy));
            check($sformatf("v%0d ovf", v), 32'(ovf), 32'(tbl[v].exp_ovf));
            check($sformatf("v%0d drop_cnt", v), 32'(drop_cnt), STATS ? 32'(tbl[v].exp_cnt) : 32'd0);
        end

        // bank tag is captured at request time even if sw flips before the drain
        do_reset();
        sw = 1'b0;
        req = '1;
        set_srcs(11'h060, 12'h600);
        @(posedge clk);
        #1;
        req = '0;
        sw = 1'b1;
        na = 0;
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            na += int'(wren_a);
            nb += int'(wren_b);
            if (wren_a && wren_b) check("bank both enables", 32'd1, 32'd0);
        end
        check("bank writes to B", 32'(nb), 32'd5);
        check("bank writes to A", 32'(na), 32'd0);
        check("bank busy after", 32'(busy), 32'd0);

        // reset in the middle of a drain discards pending entries
        do_reset();
        sw = 1'b0;
        req = 5'b01111;
        set_srcs(11'h070, 12'h700);
        @(posedge clk);
        #1;
        req = '0;
        @(posedge clk);
        #1;
        check("middrain pre wren_b", 32'(wren_b), 32'd1);
        check("middrain pre busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("middrain rst wren_a", 32'(wren_a), 32'd0);
        check("middrain rst wren_b", 32'(wren_b), 32'd0);
        check("middrain rst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        na = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            na += int'(wren_a) + int'(wren_b);
        end
        check("middrain writes after rst", 32'(na), 32'd0);
        check("middrain busy after rst", 32'(busy), 32'd0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(15) == 0) sw = ~sw;
            if ((c / 100) % 2 == 0) begin
                req = N'($urandom);
            end else begin
                req = '0;
                for (int i = 0; i < N; i++) req[i] = ($urandom_range(3) == 0);
            end
            clr_ovf = ($urandom_range(31) == 0);
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW] = AW'($urandom);
                data[i*DW +: DW] = DW'($urandom);
            end
            model_edge();
            @(posedge clk);
            #1;
            check("rnd wren_a", 32'(wren_a), 32'(m_wa));
            check("rnd wren_b", 32'(wren_b), 32'(m_wb));
            check("rnd wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            check("rnd wr_data", 32'(wr_data), 32'(m_wr_data));
            check("rnd busy", 32'(busy), 32'(model_busy()));
            check("rnd ovf", 32'(ovf), 32'(m_ovf));
            check("rnd drop_cnt", 32'(drop_cnt), STATS ? 32'(m_cnt) : 32'd0);
        end
        req = '0;
        clr_ovf = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
